uart_servo_cmd_ctrl: RTL and testbench
======================================

// Module: uart_servo_cmd_ctrl
// PURPOSE
//  Frame-level controller that sequences the UART byte receiver and turns received bytes into servo position writes.
//  - Drives the receiver's RxEn/NBits and edge-detects its RxDone.
//  - Assembles 5-byte command frames, checks them, and issues one write strobe per valid frame.
//  - Sits between the RS-232 receiver and the servo PWM position register bank.
// PARAMETERS
//  NUM_SERVOS   4         servo channels addressable; valid IDs 0..NUM_SERVOS-1
//  HDR_BYTE     8'hA5     frame start marker
//  POS_MAX      16'd2000  upper clamp applied to the received position
//  TIMEOUT_CLKS 500000    max Clk cycles between consecutive bytes inside a frame
// PORTS
//  Clk        in   1   system clock
//  Rst        in   1   synchronous reset, active-high
//  Enable     in   1   1 = accept frames; 0 = receiver disabled, FSM held in IDLE
//  RxDone     in   1   receiver byte-done level (Tick domain, may stay high many Clk)
//  RxData     in   8   received byte, stable while RxDone high
//  RxEn       out  1   receiver enable (registered copy of Enable)
//  NBits      out  4   receiver data width, constant 4'd8
//  PosWrEn    out  1   one-Clk write strobe to the servo position bank
//  PosAddr    out  clog2(NUM_SERVOS)  servo ID for PosWrEn
//  PosData    out  16  clamped position for PosWrEn
//  FrameErr   out  1   one-Clk pulse on any discarded frame
//  ErrCount   out  8   saturating count of discarded frames
// BEHAVIOUR
//  Reset: RxEn=0, NBits=8, PosWrEn=0, PosAddr=0, PosData=0, FrameErr=0, ErrCount=0, FSM=IDLE, timer=0.
//  Byte strobe: byte_v = RxDone & ~RxDone_q (RxDone_q is a 2-FF synchroniser output).
//   - RxData is sampled on the same Clk as byte_v.
//   - Exactly one byte_v per RxDone high period.
//  Frame: HDR_BYTE, ID, POS_H, POS_L, CHK, where CHK = ID ^ POS_H ^ POS_L.
//  FSM states: IDLE -> GET_ID -> GET_PH -> GET_PL -> GET_CHK -> IDLE.
//   - IDLE: byte_v with byte==HDR_BYTE -> GET_ID. Any other byte is dropped silently (no error).
//   - GET_ID/GET_PH/GET_PL: byte_v latches the field and advances.
//   - GET_CHK: on byte_v, the frame is valid iff CHK matches AND ID < NUM_SERVOS.
//     - Valid: the next Clk asserts PosWrEn for 1 cycle, with PosData = min({POS_H,POS_L}, POS_MAX) and PosAddr = ID.
//     - Invalid: the next Clk pulses FrameErr and ErrCount++.
//     - Either case returns to IDLE.
//  Latency: last byte_v -> PosWrEn/FrameErr is exactly 1 Clk.
//   - PosAddr/PosData hold their value until the next write.
//  Timeout: the timer clears on every byte_v and counts in every non-IDLE state.
//   - When timer reaches TIMEOUT_CLKS-1: FrameErr pulse, ErrCount++, FSM returns to IDLE.
//   - If a byte_v arrives on that same Clk, the byte wins: it is consumed and there is no timeout.
//  Header inside a frame: HDR_BYTE seen in GET_ID..GET_CHK is treated as data (no resync).
//  Enable=0 mid-frame: FSM -> IDLE next Clk and the partial frame is dropped.
//   - No FrameErr, no ErrCount change.
//   - RxEn follows Enable with 1 Clk delay.
//  ErrCount saturates at 8'hFF, never wraps.
//  Rst mid-frame: all state returns to reset values on that Clk. No PosWrEn is emitted.
// STRUCTURE
//  Shared package uart_servo_pkg:
//   - FSM state enum.
//   - HDR_BYTE default.
//   - Frame length constant (5).
//   - Function chk8(id,ph,pl).
//  Sub-module rxdone_sync_edge: 2-FF synchroniser plus rising-edge detect producing byte_v.
//  All remaining logic (FSM, timer, clamp, counter) lives in this module.
// TESTING
//  1. Frame A5 01 05 DC D8 -> one PosWrEn, PosAddr=1, PosData=16'h05DC (1500), FrameErr=0.
//  2. Frame A5 02 0F A0 AD (4000) -> PosWrEn with PosData=2000 (clamped), PosAddr=2.
//  3. Bad checksum A5 01 05 DC 00 -> no PosWrEn, one FrameErr, ErrCount=1.
//     - Then ID=7 with a correct checksum -> ErrCount=2.
//  4. Send A5 01, idle TIMEOUT_CLKS cycles -> FrameErr, ErrCount+1.
//     - A following full valid frame is accepted.
//  5. RxDone held high 40 Clk per byte, with garbage bytes 00 FF before A5 -> exactly one write, no errors.
//  6. Enable dropped after A5 03 -> FSM IDLE, no FrameErr.
//     - Re-enable and send a valid frame -> write accepted.
//     - Rst asserted mid-frame -> all outputs at reset values.

Source files
------------

// File: rtl/uart_servo_pkg.sv
// Shared definitions for the UART servo command controller.
//  - state_e   : frame assembly FSM states
//  - HDR_BYTE_DEF : default frame start marker
//  - FRAME_LEN : bytes per command frame (header, id, pos_h, pos_l, chk)
//  - chk8()    : frame checksum over the three payload bytes
package uart_servo_pkg;

  localparam int          FRAME_LEN    = 5;
  localparam logic [7:0]  HDR_BYTE_DEF = 8'hA5;

  // One state per frame byte; the header is consumed while in IDLE.
  typedef enum logic [$clog2(FRAME_LEN)-1:0] {
    ST_IDLE    = 3'd0,
    ST_GET_ID  = 3'd1,
    ST_GET_PH  = 3'd2,
    ST_GET_PL  = 3'd3,
    ST_GET_CHK = 3'd4
  } state_e;

  function automatic logic [7:0] chk8(input logic [7:0] id,
                                      input logic [7:0] ph,
                                      input logic [7:0] pl);
    return id ^ ph ^ pl;
  endfunction

endpackage

// File: rtl/rxdone_sync_edge.sv
// Brings the receiver's RxDone level into the Clk domain through a 2-FF
// synchroniser and produces a single-cycle byte strobe on its rising edge.
// Ports:
//  clk_i      system clock
//  rst_i      synchronous active-high reset
//  rx_done_i  asynchronous byte-done level from the receiver
//  byte_v_o   one-Clk strobe per RxDone high period
module rxdone_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_done_i,
  output logic byte_v_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchroniser chain plus one delay stage for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= rx_done_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign byte_v_o = sync_q & ~prev_q;

endmodule

// File: rtl/uart_servo_cmd_ctrl.sv
// Frame-level controller between the RS-232 byte receiver and the servo PWM
// position bank. Assembles 5-byte frames (A5, ID, POS_H, POS_L, CHK), checks
// them and emits one position write per valid frame.
// Ports:
//  Clk, Rst   clock and synchronous active-high reset
//  Enable     accept frames; low holds the FSM in IDLE
//  RxDone     receiver byte-done level (other domain); RxData its byte
//  RxEn       registered copy of Enable; NBits constant 8
//  PosWrEn    one-Clk write strobe with PosAddr / PosData (held until next write)
//  FrameErr   one-Clk pulse per discarded frame; ErrCount saturating count
module uart_servo_cmd_ctrl
  import uart_servo_pkg::*;
#(
  parameter int          NUM_SERVOS   = 4,
  parameter logic [7:0]  HDR_BYTE     = HDR_BYTE_DEF,
  parameter logic [15:0] POS_MAX      = 16'd2000,
  parameter int          TIMEOUT_CLKS = 500000,
  localparam int         AW = (NUM_SERVOS > 1) ? $clog2(NUM_SERVOS) : 1
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Enable,
  input  logic          RxDone,
  input  logic [7:0]    RxData,
  output logic          RxEn,
  output logic [3:0]    NBits,
  output logic          PosWrEn,
  output logic [AW-1:0] PosAddr,
  output logic [15:0]   PosData,
  output logic          FrameErr,
  output logic [7:0]    ErrCount
);

  localparam int          TW       = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

  logic          byte_v;
  state_e        state_q;
  logic [7:0]    id_q, ph_q, pl_q;
  logic [TW-1:0] timer_q;
  logic          rx_en_q, pos_wr_en_q, frame_err_q;
  logic [AW-1:0] pos_addr_q;
  logic [15:0]   pos_data_q;
  logic [7:0]    err_count_q;

  logic [15:0]   pos_clamp_d;
  logic          frame_ok_d;
  logic [7:0]    err_count_d;

  rxdone_sync_edge u_sync (
    .clk_i     (Clk),
    .rst_i     (Rst),
    .rx_done_i (RxDone),
    .byte_v_o  (byte_v)
  );

  // Frame verdict and clamped position, evaluated against the CHK byte on RxData.
  always_comb begin
    pos_clamp_d = ({ph_q, pl_q} > POS_MAX) ? POS_MAX : {ph_q, pl_q};
    frame_ok_d  = (RxData == chk8(id_q, ph_q, pl_q)) &&
                  ({24'd0, id_q} < 32'(NUM_SERVOS));
    err_count_d = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;
  end

  // Frame FSM, inter-byte timer and registered outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= ST_IDLE;
      id_q        <= 8'd0;
      ph_q        <= 8'd0;
      pl_q        <= 8'd0;
      timer_q     <= '0;
      rx_en_q     <= 1'b0;
      pos_wr_en_q <= 1'b0;
      pos_addr_q  <= '0;
      pos_data_q  <= 16'd0;
      frame_err_q <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      rx_en_q     <= Enable;
      pos_wr_en_q <= 1'b0;
      frame_err_q <= 1'b0;
      if (!Enable) begin
        // Partial frame is dropped silently.
        state_q <= ST_IDLE;
        timer_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (byte_v && (RxData == HDR_BYTE)) state_q <= ST_GET_ID;
          end
          ST_GET_ID: begin
            if (byte_v) begin
              id_q    <= RxData;
              state_q <= ST_GET_PH;
            end
          end
          ST_GET_PH: begin
            if (byte_v) begin
              ph_q    <= RxData;
              state_q <= ST_GET_PL;
            end
          end
          ST_GET_PL: begin
            if (byte_v) begin
              pl_q    <= RxData;
              state_q <= ST_GET_CHK;
            end
          end
          ST_GET_CHK: begin
            if (byte_v) begin
              state_q <= ST_IDLE;
              if (frame_ok_d) begin
                pos_wr_en_q <= 1'b1;
                pos_addr_q  <= id_q[AW-1:0];
                pos_data_q  <= pos_clamp_d;
              end else begin
                frame_err_q <= 1'b1;
                err_count_q <= err_count_d;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase

        // A byte arriving on the expiry cycle wins over the timeout.
        if (state_q == ST_IDLE) begin
          timer_q <= '0;
        end else if (byte_v) begin
          timer_q <= '0;
        end else if (timer_q == TMO_LAST) begin
          timer_q     <= '0;
          state_q     <= ST_IDLE;
          frame_err_q <= 1'b1;
          err_count_q <= err_count_d;
        end else begin
          timer_q <= timer_q + TW'(1);
        end
      end
    end
  end

  assign RxEn     = rx_en_q;
  assign NBits    = 4'd8;
  assign PosWrEn  = pos_wr_en_q;
  assign PosAddr  = pos_addr_q;
  assign PosData  = pos_data_q;
  assign FrameErr = frame_err_q;
  assign ErrCount = err_count_q;

endmodule

// File: tb/tb_uart_servo_cmd_ctrl.sv
module tb_uart_servo_cmd_ctrl;

  localparam int TMO = 200;

  logic        Clk = 1'b0;
  logic        Rst, Enable, RxDone;
  logic [7:0]  RxData;
  logic        RxEn, PosWrEn, FrameErr;
  logic [3:0]  NBits;
  logic [1:0]  PosAddr;
  logic [15:0] PosData;
  logic [7:0]  ErrCount;

  uart_servo_cmd_ctrl #(.NUM_SERVOS(4), .TIMEOUT_CLKS(TMO)) dut (
    .Clk(Clk), .Rst(Rst), .Enable(Enable), .RxDone(RxDone), .RxData(RxData),
    .RxEn(RxEn), .NBits(NBits), .PosWrEn(PosWrEn), .PosAddr(PosAddr),
    .PosData(PosData), .FrameErr(FrameErr), .ErrCount(ErrCount)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Observed pulse counts (cycles high, so a stretched pulse over-counts).
  int mon_wr = 0;
  int mon_errp = 0;
  always @(negedge Clk) begin
    if (PosWrEn === 1'b1) mon_wr++;
    if (FrameErr === 1'b1) mon_errp++;
  end

  // Reference model: frame collected as a byte queue, judged by frame rules.
  logic [7:0]  mfrm[$];
  int          exp_wr = 0, exp_errp = 0, exp_errcnt = 0, exp_addr = 0, exp_data = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_err();
    exp_errp++;
    if (exp_errcnt < 255) exp_errcnt++;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int pos;
    if (mfrm.size() == 0) begin
      if (b == 8'hA5) mfrm.push_back(b);
    end else begin
      mfrm.push_back(b);
      if (mfrm.size() == 5) begin
        pos = mfrm[2] * 256 + mfrm[3];
        if ((mfrm[1] ^ mfrm[2] ^ mfrm[3]) == mfrm[4] && mfrm[1] < 4) begin
          exp_wr++;
          exp_addr = mfrm[1];
          exp_data = (pos > 2000) ? 2000 : pos;
        end else begin
          model_err();
        end
        mfrm.delete();
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    tick(n);
    if (n >= TMO && mfrm.size() != 0) begin
      model_err();
      mfrm.delete();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    RxData = b;
    RxDone = 1'b1;
    tick(hold);
    RxDone = 1'b0;
    tick(4);
    model_byte(b);
  endtask

  task automatic send_frame(input logic [7:0] id, input logic [7:0] ph,
                            input logic [7:0] pl, input logic [7:0] ck, input int hold);
    send_byte(8'hA5, hold);
    send_byte(id, hold);
    send_byte(ph, hold);
    send_byte(pl, hold);
    send_byte(ck, hold);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/wr_cnt"},  mon_wr,         exp_wr);
    chk({tag, "/err_cnt"}, mon_errp,       exp_errp);
    chk({tag, "/ErrCount"}, {24'd0, ErrCount}, exp_errcnt);
    chk({tag, "/PosAddr"}, {30'd0, PosAddr},  exp_addr);
    chk({tag, "/PosData"}, {16'd0, PosData},  exp_data);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "/RxEn"},     {31'd0, RxEn},     32'd0);
    chk({tag, "/NBits"},    {28'd0, NBits},    32'd8);
    chk({tag, "/PosWrEn"},  {31'd0, PosWrEn},  32'd0);
    chk({tag, "/PosAddr"},  {30'd0, PosAddr},  32'd0);
    chk({tag, "/PosData"},  {16'd0, PosData},  32'd0);
    chk({tag, "/FrameErr"}, {31'd0, FrameErr}, 32'd0);
    chk({tag, "/ErrCount"}, {24'd0, ErrCount}, 32'd0);
  endtask

  initial begin
    logic [7:0] id, ph, pl, ck, g;
    logic [15:0] pos;
    Rst = 1'b1; Enable = 1'b0; RxDone = 1'b0; RxData = 8'h00;
    tick(3);
    check_reset("reset");
    Rst = 1'b0; Enable = 1'b1;
    tick(3);
    chk("rxen_on", {31'd0, RxEn}, 32'd1);

    // 1: nominal write
    send_frame(8'h01, 8'h05, 8'hDC, 8'hD8, 4);
    check_all("t1");
    // 2: position clamp
    send_frame(8'h02, 8'h0F, 8'hA0, 8'hAD, 4);
    check_all("t2");
    // 3: bad checksum, then out-of-range ID
    send_frame(8'h01, 8'h05, 8'hDC, 8'h00, 4);
    check_all("t3a");
    send_frame(8'h07, 8'h00, 8'h10, 8'h17, 4);
    check_all("t3b");
    // 4: inter-byte timeout, then recovery
    send_byte(8'hA5, 4);
    send_byte(8'h01, 4);
    idle(TMO + 20);
    check_all("t4a");
    send_frame(8'h03, 8'h01, 8'h00, 8'h02, 4);
    check_all("t4b");
    // 5: long RxDone pulses and leading garbage
    send_byte(8'h00, 40);
    send_byte(8'hFF, 40);
    send_frame(8'h00, 8'h02, 8'h58, 8'h5A, 40);
    check_all("t5");
    // 6: Enable dropped mid-frame
    send_byte(8'hA5, 4);
    send_byte(8'h03, 4);
    Enable = 1'b0;
    @(negedge Clk);
    chk("rxen_lag", {31'd0, RxEn}, 32'd1);
    @(negedge Clk);
    chk("rxen_off", {31'd0, RxEn}, 32'd0);
    tick(10);
    mfrm.delete();
    check_all("t6a");
    Enable = 1'b1;
    tick(2);
    send_frame(8'h03, 8'h01, 8'hF4, 8'hF6, 4);
    check_all("t6b");

    // Randomized frames with optional garbage and varying pulse widths
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h00;
        send_byte(g, 3);
      end
      id  = 8'($urandom_range(0, 5));
      pos = 16'($urandom);
      ph  = pos[15:8];
      pl  = pos[7:0];
      ck  = id ^ ph ^ pl;
      if ($urandom_range(0, 3) == 0) ck = ck ^ 8'($urandom_range(1, 255));
      send_frame(id, ph, pl, ck, $urandom_range(3, 10));
      check_all("rand");
    end

    // ErrCount saturation
    for (int i = 0; i < 260; i++) send_frame(8'h09, 8'h00, 8'h00, 8'h09, 3);
    check_all("sat");

    // Reset mid-frame: outputs return to reset values, remainder ignored
    send_byte(8'hA5, 4);
    send_byte(8'h01, 4);
    send_byte(8'h05, 4);
    Rst = 1'b1;
    tick(1);
    check_reset("rst_mid");
    Rst = 1'b0;
    mfrm.delete();
    exp_errcnt = 0; exp_addr = 0; exp_data = 0;
    tick(2);
    send_byte(8'hDC, 4);
    send_byte(8'hD8, 4);
    check_all("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
